dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 19 +
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: FSM states, read-owner tags and
// the default length of a locked debug burst.
package dmem_arbiter_pkg;

  localparam int LOCK_MAX_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IDLE_D = 2'd1,
    ST_LOCKED = 2'd2
  } arbState_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Two-port (core / debug) arbiter onto a single-ported data memory, with
// round-robin fairness and a bounded back-to-back lock for the debug port.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int LOCK_MAX = LOCK_MAX_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_stall,
  output logic              core_rvalid,
  output logic [DATA_W-1:0] core_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_wr,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W      = $clog2(LOCK_MAX + 1);
  localparam logic [CNT_W-1:0] LOCK_MAX_C = CNT_W'(LOCK_MAX);

  arbState_t        stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  owner_t           ownerQ, ownerD;
  logic             coreWin, dbgWin, lockHold;

  // Arbitration and next-state; a dropped lock falls back to IDLE_D rules at once.
  always_comb begin
    coreWin  = 1'b0;
    dbgWin   = 1'b0;
    stateD   = stateQ;
    cntD     = cntQ;
    lockHold = (stateQ == ST_LOCKED) && dbg_req && dbg_lock;
    if (lockHold) begin
      if ((cntQ == LOCK_MAX_C) && core_req) begin
        coreWin = 1'b1;
        stateD  = ST_IDLE;
        cntD    = '0;
      end else begin
        dbgWin = 1'b1;
        if (cntQ != LOCK_MAX_C) cntD = cntQ + CNT_W'(1);
      end
    end else begin
      if (core_req && dbg_req) begin
        if (stateQ == ST_IDLE) dbgWin = 1'b1;
        else                   coreWin = 1'b1;
      end else if (core_req) begin
        coreWin = 1'b1;
      end else if (dbg_req) begin
        dbgWin = 1'b1;
      end
      if (coreWin) begin
        stateD = ST_IDLE;
        cntD   = '0;
      end else if (dbgWin) begin
        stateD = dbg_lock ? ST_LOCKED : ST_IDLE_D;
        cntD   = dbg_lock ? CNT_W'(1) : '0;
      end else if (stateQ == ST_LOCKED) begin
        stateD = ST_IDLE_D;
        cntD   = '0;
      end
    end
  end

  always_comb begin
    ownerD = OWN_NONE;
    if (core_gnt && !core_we)     ownerD = OWN_CORE;
    else if (dbg_gnt && !dbg_we)  ownerD = OWN_DBG;
  end

  // Reset parks in IDLE_D so the core wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ <= ST_IDLE_D;
      cntQ   <= '0;
      ownerQ <= OWN_NONE;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      ownerQ <= ownerD;
    end
  end

  assign core_gnt   = coreWin && !reset;
  assign dbg_gnt    = dbgWin && !reset;
  assign core_stall = core_req && !core_gnt && !reset;

  assign mem_rd    = (core_gnt && !core_we) || (dbg_gnt && !dbg_we);
  assign mem_wr    = (core_gnt && core_we) || (dbg_gnt && dbg_we);
  assign mem_addr  = core_gnt ? core_addr  : (dbg_gnt ? dbg_addr  : '0);
  assign mem_wdata = core_gnt ? core_wdata : (dbg_gnt ? dbg_wdata : '0);

  assign core_rvalid = (ownerQ == OWN_CORE) && !reset;
  assign dbg_rvalid  = (ownerQ == OWN_DBG) && !reset;
  assign core_rdata  = core_rvalid ? mem_rdata : '0;
  assign dbg_rdata   = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: stimulus pushes expected read
// responses, a negedge monitor pops and checks them when rvalid appears.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [8:0]  core_addr = '0;
  logic [31:0] core_wdata = '0;
  logic        core_gnt, core_stall, core_rvalid;
  logic [31:0] core_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [8:0]  dbg_addr = '0;
  logic [31:0] dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_wr, mem_rd;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  typedef struct {
    bit          isDbg;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] memArr [0:511];
  int          checks = 0;
  int          fails = 0;
  int          cycleCnt = 0;

  dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .LOCK_MAX(16)) dut (
    .clk(clk), .reset(reset),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_gnt(core_gnt), .core_stall(core_stall),
    .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_wr(mem_wr), .mem_rd(mem_rd), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port memory model: read data returns the cycle after mem_rd.
  always @(posedge clk) begin
    cycleCnt <= cycleCnt + 1;
    if (mem_wr) memArr[mem_addr] <= mem_wdata;
    if (mem_rd) mem_rdata <= memArr[mem_addr];
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycleCnt);
    end
  endtask

  task automatic applyStimulus(input logic rst,
                               input logic cReq, input logic cWe, input logic [8:0] cAddr,
                               input logic [31:0] cWdata,
                               input logic dReq, input logic dWe, input logic [8:0] dAddr,
                               input logic [31:0] dWdata, input logic dLock);
    @(posedge clk);
    #1;
    reset      = rst;
    core_req   = cReq;
    core_we    = cWe;
    core_addr  = cAddr;
    core_wdata = cWdata;
    dbg_req    = dReq;
    dbg_we     = dWe;
    dbg_addr   = dAddr;
    dbg_wdata  = dWdata;
    dbg_lock   = dLock;
    @(negedge clk);
  endtask

  task automatic pushExp(input bit isDbg, input logic [31:0] data);
    exp_t e;
    e.isDbg = isDbg;
    e.data  = data;
    e.due   = cycleCnt + 1;
    expQ.push_back(e);
  endtask

  // Monitor: every rvalid must match the oldest outstanding expected read.
  always @(negedge clk) begin
    if (core_rvalid || dbg_rvalid) begin
      if (expQ.size() == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected rvalid: core=%0b dbg=%0b, expected none (cycle %0d)",
                 core_rvalid, dbg_rvalid, cycleCnt);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("rvalid one-hot", {63'd0, core_rvalid && dbg_rvalid}, 64'd0);
        checkOutput("rvalid owner", {63'd0, dbg_rvalid}, {63'd0, e.isDbg});
        checkOutput("rvalid latency", 64'(cycleCnt), 64'(e.due));
        checkOutput("owner rdata", {32'd0, dbg_rvalid ? dbg_rdata : core_rdata}, {32'd0, e.data});
        checkOutput("non-owner rdata", {32'd0, dbg_rvalid ? core_rdata : dbg_rdata}, 64'd0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 512; i++) memArr[i] = 32'h0;
    memArr[9'h010] = 32'h1111_0010;
    memArr[9'h020] = 32'h2222_0020;

    // Reset with both requesting: everything must stay quiet.
    applyStimulus(1, 1, 0, 9'h010, 0, 1, 0, 9'h020, 0, 0);
    applyStimulus(1, 1, 0, 9'h010, 0, 1, 0, 9'h020, 0, 0);
    checkOutput("reset core_gnt", {63'd0, core_gnt}, 64'd0);
    checkOutput("reset dbg_gnt", {63'd0, dbg_gnt}, 64'd0);
    checkOutput("reset mem_rd", {63'd0, mem_rd}, 64'd0);
    checkOutput("reset core_stall", {63'd0, core_stall}, 64'd0);

    // Tie after reset: core first, then debug.
    applyStimulus(0, 1, 0, 9'h010, 0, 1, 0, 9'h020, 0, 0);
    checkOutput("tie1 core_gnt", {63'd0, core_gnt}, 64'd1);
    checkOutput("tie1 dbg_gnt", {63'd0, dbg_gnt}, 64'd0);
    checkOutput("tie1 mem_addr", {55'd0, mem_addr}, 64'h010);
    checkOutput("tie1 mem_rd", {63'd0, mem_rd}, 64'd1);
    pushExp(0, 32'h1111_0010);
    applyStimulus(0, 1, 0, 9'h010, 0, 1, 0, 9'h020, 0, 0);
    checkOutput("tie2 dbg_gnt", {63'd0, dbg_gnt}, 64'd1);
    checkOutput("tie2 core_gnt", {63'd0, core_gnt}, 64'd0);
    checkOutput("tie2 mem_addr", {55'd0, mem_addr}, 64'h020);
    checkOutput("tie2 core_stall", {63'd0, core_stall}, 64'd1);
    pushExp(1, 32'h2222_0020);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("idle mem_addr", {55'd0, mem_addr}, 64'd0);

    // Core writes, debug reads back.
    applyStimulus(0, 1, 1, 9'h1FF, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    checkOutput("wr core_gnt", {63'd0, core_gnt}, 64'd1);
    checkOutput("wr mem_wr", {63'd0, mem_wr}, 64'd1);
    checkOutput("wr mem_rd", {63'd0, mem_rd}, 64'd0);
    checkOutput("wr mem_addr", {55'd0, mem_addr}, 64'h1FF);
    checkOutput("wr mem_wdata", {32'd0, mem_wdata}, 64'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 9'h1FF, 0, 0);
    checkOutput("rd dbg_gnt", {63'd0, dbg_gnt}, 64'd1);
    checkOutput("rd no core_rvalid", {63'd0, core_rvalid}, 64'd0);
    pushExp(1, 32'hDEADBEEF);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Locked burst: core, 16 debug, core, then debug again.
    for (int i = 0; i < 19; i++) begin
      bit expDbg;
      expDbg = ((i >= 1) && (i <= 16)) || (i == 18);
      applyStimulus(0, 1, 1, 9'h100, 32'hC0DE, 1, 1, 9'h101, 32'hDB6, 1);
      checkOutput($sformatf("lock dbg_gnt[%0d]", i), {63'd0, dbg_gnt}, {63'd0, expDbg});
      checkOutput($sformatf("lock core_gnt[%0d]", i), {63'd0, core_gnt}, {63'd0, !expDbg});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Lock dropped after three locked grants hands over to the core.
    applyStimulus(0, 0, 1, 9'h102, 0, 1, 1, 9'h103, 0, 1);
    checkOutput("drop g1 dbg_gnt", {63'd0, dbg_gnt}, 64'd1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 1, 9'h102, 0, 1, 1, 9'h103, 0, 1);
      checkOutput("drop locked dbg_gnt", {63'd0, dbg_gnt}, 64'd1);
      checkOutput("drop locked core_stall", {63'd0, core_stall}, 64'd1);
    end
    applyStimulus(0, 1, 1, 9'h102, 0, 1, 1, 9'h103, 0, 0);
    checkOutput("drop core_gnt", {63'd0, core_gnt}, 64'd1);
    checkOutput("drop dbg_gnt", {63'd0, dbg_gnt}, 64'd0);

    // Read granted, then reset: the pending read must vanish.
    applyStimulus(0, 1, 0, 9'h010, 0, 0, 0, 0, 0, 0);
    checkOutput("prerst core_gnt", {63'd0, core_gnt}, 64'd1);
    applyStimulus(1, 1, 0, 9'h010, 32'h5555, 1, 1, 9'h020, 32'h6666, 1);
    checkOutput("rst core_rvalid", {63'd0, core_rvalid}, 64'd0);
    checkOutput("rst core_rdata", {32'd0, core_rdata}, 64'd0);
    checkOutput("rst gnts", {62'd0, core_gnt, dbg_gnt}, 64'd0);
    checkOutput("rst mem strobes", {62'd0, mem_wr, mem_rd}, 64'd0);
    checkOutput("rst mem_addr", {55'd0, mem_addr}, 64'd0);
    checkOutput("rst mem_wdata", {32'd0, mem_wdata}, 64'd0);
    checkOutput("rst core_stall", {63'd0, core_stall}, 64'd0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Random write traffic: grant exclusivity and stall definition.
    for (int i = 0; i < 200; i++) begin
      logic cr, dr, dl;
      cr = 1'($urandom_range(0, 1));
      dr = 1'($urandom_range(0, 1));
      dl = 1'($urandom_range(0, 1));
      applyStimulus(0, cr, 1, 9'($urandom), $urandom, dr, 1, 9'($urandom), $urandom, dl);
      checkOutput("rand one-hot", {63'd0, core_gnt && dbg_gnt}, 64'd0);
      checkOutput("rand single grant", {63'd0, core_gnt || dbg_gnt}, {63'd0, cr || dr});
      checkOutput("rand core_stall", {63'd0, core_stall}, {63'd0, cr && !core_gnt});
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
